// File: rtl/imem_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loadable
//  Description : Run-time loadable instruction memory for the lab single-cycle
//                CPU. After reset a sequencer zeroes the array one word per
//                cycle. A streaming valid/ready port then writes a program image
//                sequentially from word 0. The fetch port is a zero-latency
//                combinational read on a byte address. It also reports
//                misalignment and out-of-range flags.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: IMEM_PARITY_EN
//      defined   - each entry carries an even-parity bit. PARITY_ERR is live.
//                  The LD_PFLIP input exists and corrupts the stored parity
//                  on load writes.
//      undefined - data-only entries. PARITY_ERR is tied low. No LD_PFLIP.
// ----------------------------------------------------------------------------
//  Ports
//      CLK         in   clock, all state changes on the rising edge
//      RESET       in   synchronous active-high reset
//      ADDR        in   fetch byte address, word index = ADDR[ADDR_W-1:1]
//      Q           out  fetched word; 0 while busy or out of range
//      MISALIGN    out  ADDR[0]
//      RANGE_ERR   out  word index >= DEPTH
//      PARITY_ERR  out  stored parity mismatch on the current fetch
//      BUSY        out  clear or load in progress
//      LD_START    in   start a new load (honoured only in IDLE)
//      LD_VALID    in   LD_DATA is valid
//      LD_DATA     in   word to write
//      LD_LAST     in   final word of the image
//      LD_PFLIP    in   (IMEM_PARITY_EN only) invert stored parity on write
//      LD_READY    out  load port accepting
//      LD_DONE     out  one-cycle pulse after a load completes
//      LD_COUNT    out  words written by the most recent load
// ============================================================================
module imem_loadable #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [ADDR_W-1:0]        ADDR,
    output logic [DATA_W-1:0]        Q,
    output logic                     MISALIGN,
    output logic                     RANGE_ERR,
    output logic                     PARITY_ERR,
    output logic                     BUSY,
    input  logic                     LD_START,
    input  logic                     LD_VALID,
    input  logic [DATA_W-1:0]        LD_DATA,
    input  logic                     LD_LAST,
`ifdef IMEM_PARITY_EN
    input  logic                     LD_PFLIP,
`endif
    output logic                     LD_READY,
    output logic                     LD_DONE,
    output logic [$clog2(DEPTH):0]   LD_COUNT
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_IDX_W = ADDR_W - 1;

`ifdef IMEM_PARITY_EN
    localparam int c_ENT_W = DATA_W + 1;   // parity bit sits above the data
`else
    localparam int c_ENT_W = DATA_W;
`endif

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);

    // State encoding. CLEAR is the all-zero code so that it is also the
    // natural power-up value of the state register.
    localparam logic [1:0] c_S_CLEAR = 2'd0;
    localparam logic [1:0] c_S_IDLE  = 2'd1;
    localparam logic [1:0] c_S_LOAD  = 2'd2;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_PTR_W-1:0]     r_ptr;
    logic                   r_done;
    logic [c_CNT_W-1:0]     r_count;

    logic [c_ENT_W-1:0]     r_mem [DEPTH];

    logic                   w_clr_we;     // sequencer zeroing mem[r_ptr]
    logic                   w_ld_we;      // load port writing mem[r_ptr]
    logic                   w_ld_end;     // current word ends the load
    logic [c_ENT_W-1:0]     w_wr_ent;     // entry image for a load write

    logic [c_IDX_W-1:0]     w_idx;
    logic [c_ENT_W-1:0]     w_rd_ent;
    logic                   w_rd_ok;

    // A load ends on an explicit LD_LAST or on the word that fills the array.
    assign w_ld_end = LD_LAST || (r_ptr == c_PTR_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_CLEAR: begin
                if (r_ptr == c_PTR_LAST) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_IDLE: begin
                if (LD_START) begin
                    w_state_nxt = c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                if (LD_VALID && w_ld_end) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and write strobes
    // ------------------------------------------------------------------
    always_comb begin
        BUSY     = 1'b1;
        LD_READY = 1'b0;
        w_clr_we = 1'b0;
        w_ld_we  = 1'b0;
        case (r_state)
            c_S_CLEAR: begin
                w_clr_we = 1'b1;
            end
            c_S_IDLE: begin
                BUSY = 1'b0;
            end
            c_S_LOAD: begin
                LD_READY = 1'b1;
                w_ld_we  = LD_VALID;
            end
            default: begin
                BUSY = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write pointer, completion pulse and word count
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ptr   <= '0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_CLEAR: begin
                    // Wraps to 0 on the last clear write, ready for a load.
                    r_ptr <= r_ptr + 1'b1;
                end
                c_S_IDLE: begin
                    if (LD_START) begin
                        r_ptr <= '0;
                    end
                end
                c_S_LOAD: begin
                    if (LD_VALID) begin
                        r_ptr <= r_ptr + 1'b1;
                        if (w_ld_end) begin
                            r_done  <= 1'b1;
                            r_count <= c_CNT_W'(r_ptr) + c_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_ptr <= '0;
                end
            endcase
        end
    end

    assign LD_DONE  = r_done;
    assign LD_COUNT = r_count;

    // ------------------------------------------------------------------
    // Storage array (no reset: it is zeroed by the clear sequencer)
    // ------------------------------------------------------------------
`ifdef IMEM_PARITY_EN
    // Even parity over data+parity; LD_PFLIP deliberately corrupts it.
    assign w_wr_ent = {(^LD_DATA) ^ LD_PFLIP, LD_DATA};
`else
    assign w_wr_ent = LD_DATA;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (w_clr_we) begin
                r_mem[r_ptr] <= '0;
            end else if (w_ld_we) begin
                r_mem[r_ptr] <= w_wr_ent;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fetch port (combinational)
    // ------------------------------------------------------------------
    assign w_idx     = ADDR[ADDR_W-1:1];
    assign MISALIGN  = ADDR[0];
    // Zero-extend the index by one bit so that DEPTH == 2^(ADDR_W-1)
    // is representable in the comparison.
    assign RANGE_ERR = ({1'b0, w_idx} >= ADDR_W'(DEPTH));
    assign w_rd_ent  = r_mem[w_idx[c_PTR_W-1:0]];
    assign w_rd_ok   = !BUSY && !RANGE_ERR;
    assign Q         = w_rd_ok ? w_rd_ent[DATA_W-1:0] : '0;

`ifdef IMEM_PARITY_EN
    assign PARITY_ERR = w_rd_ok && (^w_rd_ent);
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loadable.sv
`default_nettype none
module tb_imem_loadable;

    localparam int DW = 16;
    localparam int AW = 9;     // one spare address bit so index 128 is reachable
    localparam int DP = 128;
    localparam int CW = 8;

`ifdef IMEM_PARITY_EN
    localparam logic PF_EXP = 1'b1;
`else
    localparam logic PF_EXP = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic [AW-1:0]   ADDR = '0;
    logic [DW-1:0]   Q;
    logic            MISALIGN, RANGE_ERR, PARITY_ERR, BUSY;
    logic            LD_START = 1'b0;
    logic            LD_VALID = 1'b0;
    logic [DW-1:0]   LD_DATA = '0;
    logic            LD_LAST = 1'b0;
`ifdef IMEM_PARITY_EN
    logic            LD_PFLIP = 1'b0;
`endif
    logic            LD_READY, LD_DONE;
    logic [CW-1:0]   LD_COUNT;

    always #5 CLK = ~CLK;

    imem_loadable #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ADDR       (ADDR),
        .Q          (Q),
        .MISALIGN   (MISALIGN),
        .RANGE_ERR  (RANGE_ERR),
        .PARITY_ERR (PARITY_ERR),
        .BUSY       (BUSY),
        .LD_START   (LD_START),
        .LD_VALID   (LD_VALID),
        .LD_DATA    (LD_DATA),
        .LD_LAST    (LD_LAST),
`ifdef IMEM_PARITY_EN
        .LD_PFLIP   (LD_PFLIP),
`endif
        .LD_READY   (LD_READY),
        .LD_DONE    (LD_DONE),
        .LD_COUNT   (LD_COUNT)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] q;
        logic          mis;
        logic          rng;
        logic          perr;
        logic          busy;
    } fx_t;

    fx_t           fq[$];     // expected fetch responses
    logic [CW-1:0] dq[$];     // expected LD_COUNT per LD_DONE pulse
    logic          chk_req = 1'b0;
    int            total = 0;
    int            bad = 0;
    fx_t           me;
    logic [CW-1:0] md;

    // Monitor: compares whenever a fetch is presented or LD_DONE pulses.
    always @(negedge CLK) begin
        if (chk_req) begin
            total++;
            if (fq.size() == 0) begin
                bad++;
                $display("FAIL fetch: response with no expectation queued");
            end else begin
                me = fq.pop_front();
                if ({Q, MISALIGN, RANGE_ERR, PARITY_ERR, BUSY} !==
                    {me.q, me.mis, me.rng, me.perr, me.busy}) begin
                    bad++;
                    $display("FAIL fetch addr=%h: got q=%h mis=%b rng=%b perr=%b busy=%b want q=%h mis=%b rng=%b perr=%b busy=%b",
                             me.a, Q, MISALIGN, RANGE_ERR, PARITY_ERR, BUSY,
                             me.q, me.mis, me.rng, me.perr, me.busy);
                end
            end
        end
        if (LD_DONE !== 1'b0) begin
            total++;
            if (dq.size() == 0) begin
                bad++;
                $display("FAIL ld_done: unexpected pulse (LD_DONE=%b) count=%0d", LD_DONE, LD_COUNT);
            end else begin
                md = dq.pop_front();
                if (LD_COUNT !== md) begin
                    bad++;
                    $display("FAIL ld_count: got %0d want %0d", LD_COUNT, md);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // All driver tasks start and end 1 ns after a rising edge.
    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] q,
                         input logic perr, input logic busy);
        fx_t e;
        e.a    = a;
        e.q    = q;
        e.mis  = a[0];
        e.rng  = (a >= 9'h100);
        e.perr = perr;
        e.busy = busy;
        ADDR = a;
        fq.push_back(e);
        chk_req = 1'b1;
        @(negedge CLK);
        #1 chk_req = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic start();
        LD_START = 1'b1;
        @(posedge CLK);
        #1 LD_START = 1'b0;
    endtask

    task automatic gap();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last, input logic pf);
        LD_VALID = 1'b1;
        LD_DATA  = d;
        LD_LAST  = last;
`ifdef IMEM_PARITY_EN
        LD_PFLIP = pf;
`endif
        @(posedge CLK);
        #1;
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
`ifdef IMEM_PARITY_EN
        LD_PFLIP = 1'b0;
`endif
    endtask

    // Counts falling edges with BUSY high after reset release; releases
    // LD_START after the first clear edge has sampled it.
    task automatic busy_count(input string nm);
        int n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (i == 1) LD_START = 1'b0;
            if (!BUSY) break;
            n++;
        end
        chk(nm, n, 128);
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_status(input string nm);
        @(negedge CLK);
        chk({nm, "_busy"},  BUSY, 1);
        chk({nm, "_ready"}, LD_READY, 0);
        chk({nm, "_done"},  LD_DONE, 0);
        chk({nm, "_count"}, LD_COUNT, 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset and clear
        repeat (2) @(posedge CLK);
        #1;
        reset_status("rst");
        fetch(9'h000, 16'h0000, 1'b0, 1'b1);
        RESET = 1'b0;
        busy_count("clear_len");
        chk("idle_ready", LD_READY, 0);
        for (int i = 0; i < DP; i++) fetch(9'(2 * i), 16'h0000, 1'b0, 1'b0);
        fetch(9'h100, 16'h0000, 1'b0, 1'b0);

        // Three-word load with a valid gap
        start();
        chk("ready_after_start", LD_READY, 1);
        send(16'h56C4, 1'b0, 1'b0);
        gap();
        send(16'h54BF, 1'b0, 1'b0);
        dq.push_back(8'd3);
        send(16'h0001, 1'b1, 1'b0);
        chk("idle_after_load", BUSY, 0);
        fetch(9'h000, 16'h56C4, 1'b0, 1'b0);
        fetch(9'h002, 16'h54BF, 1'b0, 1'b0);
        fetch(9'h004, 16'h0001, 1'b0, 1'b0);
        fetch(9'h003, 16'h54BF, 1'b0, 1'b0);
        fetch(9'h006, 16'h0000, 1'b0, 1'b0);

        // Full-array load without LD_LAST, then a one-word reload
        start();
        for (int i = 0; i < DP; i++) begin
            if (i == DP - 1) dq.push_back(8'd128);
            send(16'hA000 + 16'(i), 1'b0, 1'b0);
        end
        chk("idle_after_full", BUSY, 0);
        fetch(9'h002, 16'hA001, 1'b0, 1'b0);
        fetch(9'h0FE, 16'hA07F, 1'b0, 1'b0);
        start();
        dq.push_back(8'd1);
        send(16'h1234, 1'b1, 1'b0);
        fetch(9'h000, 16'h1234, 1'b0, 1'b0);
        fetch(9'h002, 16'hA001, 1'b0, 1'b0);

        // LD_START during LOAD is ignored
        start();
        send(16'hBEEF, 1'b0, 1'b0);
        LD_START = 1'b1;
        gap();
        LD_START = 1'b0;
        dq.push_back(8'd2);
        send(16'hCAFE, 1'b1, 1'b0);
        fetch(9'h000, 16'hBEEF, 1'b0, 1'b0);
        fetch(9'h002, 16'hCAFE, 1'b0, 1'b0);
        fetch(9'h004, 16'hA002, 1'b0, 1'b0);

        // Parity flip on a load write
        start();
        dq.push_back(8'd1);
        send(16'h0001, 1'b1, 1'b1);
        fetch(9'h000, 16'h0001, PF_EXP, 1'b0);
        fetch(9'h002, 16'hCAFE, 1'b0, 1'b0);

        // Reset aborts a load after two of five words
        start();
        send(16'h1111, 1'b0, 1'b0);
        send(16'h2222, 1'b0, 1'b0);
        LD_VALID = 1'b1;
        LD_DATA  = 16'h3333;
        RESET    = 1'b1;
        gap();
        LD_VALID = 1'b0;
        reset_status("abort");
        RESET    = 1'b0;
        LD_START = 1'b1;          // arrives during CLEAR, must be ignored
        busy_count("clear_len_abort");
        chk("abort_ready", LD_READY, 0);
        fetch(9'h000, 16'h0000, 1'b0, 1'b0);
        fetch(9'h002, 16'h0000, 1'b0, 1'b0);
        fetch(9'h004, 16'h0000, 1'b0, 1'b0);
        fetch(9'h101, 16'h0000, 1'b0, 1'b0);

        chk("done_queue_empty", dq.size(), 0);
        chk("fetch_queue_empty", fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loadable.md
# imem_loadable

Parametrised instruction memory for the lab single-cycle CPU, replacing a fixed program image hard-wired at reset with a run-time loadable store. After reset, a sequencer clears the array one word per cycle. A streaming valid/ready load port then writes a program image sequentially. The CPU fetch port stays a zero-latency combinational read on a byte address, with misalignment and out-of-range flags.

## Interface
Parameters:
- DATA_W, 16, instruction word width in bits
- ADDR_W, 8, fetch byte-address width
- DEPTH, 128, number of words; power of two, at most 2^(ADDR_W-1)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RESET  in  1  reset, synchronous and active-high
- ADDR  in  ADDR_W  fetch byte address; word index = ADDR[ADDR_W-1:1]
- Q  out  DATA_W  fetched instruction
- MISALIGN  out  1  ADDR[0]
- RANGE_ERR  out  1  word index >= DEPTH
- PARITY_ERR  out  1  parity mismatch on the current fetch (see Configuration)
- BUSY  out  1  clear or load in progress
- LD_START  in  1  request a new load; honoured only in IDLE
- LD_VALID  in  1  LD_DATA valid
- LD_DATA  in  DATA_W  word to write
- LD_LAST  in  1  marks the final word of the image
- LD_READY  out  1  load port accepting
- LD_DONE  out  1  one-cycle pulse when a load completes
- LD_COUNT  out  clog2(DEPTH)+1  words written by the most recent load

## Operation
- States: CLEAR, IDLE, LOAD. Write pointer `ptr` has clog2(DEPTH) bits.
- RESET=1 at an edge: state=CLEAR, ptr=0, LD_DONE=0, LD_COUNT=0. RESET overrides every other input in every state, including mid-load. A reset during LOAD aborts the load; words already written are then cleared.
- CLEAR:
  - Each edge with RESET=0 writes 0 to mem[ptr] and increments ptr.
  - The edge that writes mem[DEPTH-1] moves the state to IDLE.
- IDLE: BUSY=0, LD_READY=0. LD_START=1 at an edge moves the state to LOAD with ptr=0.
- LOAD:
  - LD_READY=1.
  - Each edge with LD_VALID=1 writes LD_DATA to mem[ptr] and increments ptr.
  - Completion: the accepted word has LD_LAST=1 or ptr==DEPTH-1. The state returns to IDLE. LD_COUNT becomes ptr+1, and LD_DONE is 1 for the next cycle only.
  - Words above the last written index keep their previous contents.
- LD_START is ignored in CLEAR and LOAD. LD_VALID is ignored outside LOAD.
- Fetch, all combinational:
  - BUSY=0 and index < DEPTH: Q = mem[index].
  - BUSY=1 or RANGE_ERR=1: Q = 0.
  - MISALIGN and RANGE_ERR are independent of BUSY. The misaligned address is still read from index ADDR[ADDR_W-1:1].
- BUSY = (state != IDLE).

## Timing
- Fetch latency is 0 cycles; Q follows ADDR combinationally.
- Load writes take effect at the accepting edge. A fetch of that index in a later IDLE cycle returns the new word.
- After RESET deasserts, BUSY stays high for exactly DEPTH cycles, then IDLE.
- LD_START sampled at edge N gives LD_READY=1 from edge N onward. The first word can be accepted at edge N+1.
- A k-word load (k <= DEPTH) occupies exactly k accepting edges. Gaps with LD_VALID=0 add cycles without writing.
- Output values during and after reset:
  - During reset: Q=0, BUSY=1, LD_READY=0, LD_DONE=0, LD_COUNT=0.
  - Immediately after reset: PARITY_ERR=0.
  - MISALIGN and RANGE_ERR follow ADDR at all times.

## Configuration
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each entry stores DATA_W+1 bits: data plus an even-parity bit, computed on every write. CLEAR writes 0 with parity 0.
  - PARITY_ERR = !BUSY & !RANGE_ERR & (XOR of the stored data and parity bits != 0).
  - Test-only input LD_PFLIP (1 bit) inverts the stored parity bit on load writes.
- Not defined: entries are DATA_W bits, PARITY_ERR is tied 0, and the LD_PFLIP port is absent.

## Test plan
- Reset then idle, DEPTH=128: BUSY=1 for 128 cycles after RESET falls, then 0. All ADDR 0x00..0xFE even read Q=0x0000.
- Load 3 words 0x56C4, 0x54BF, 0x0001 with LD_LAST on the third, one LD_VALID gap inserted. Expect LD_DONE pulsed once, LD_COUNT=3, and ADDR 0x00/0x02/0x04 returning those words with BUSY=0.
- Load 128 words with LD_LAST never asserted: completion on the 128th word, LD_COUNT=128. A second LD_START then a 1-word load changes only mem[0]; ADDR 0x02 keeps its old word.
- RESET asserted after 2 of 5 words: state CLEAR, and after 128 cycles ADDR 0x00 and 0x02 read 0. LD_START pulsed during CLEAR and during LOAD has no effect.
- ADDR=0x03: MISALIGN=1, Q=mem[1]. With ADDR_W=9, DEPTH=128, ADDR=0x100: RANGE_ERR=1, Q=0.
- With IMEM_PARITY_EN: load 0x0001 with LD_PFLIP=1 → PARITY_ERR=1 at that address, 0 at others. Without the macro, PARITY_ERR stays 0.
